// File: rtl/fpdiv.sv
// fpdiv: multi-cycle IEEE-754 single-precision divider, result = dataa / datab.
// Radix-2 restoring mantissa divider with a fixed-latency step counter.
// Kick-off/done protocol: dropping reset starts an operation; done marks completion.
// Denormals are flushed to zero; there is no NaN/Inf special handling.
// Optional build macro FPDIV_ROUND_EN: run one extra iteration for a guard bit,
// take a sticky bit from the final remainder, and round to nearest even.
// Default build (macro undefined): truncation, latency 28 edges.
module fpdiv #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

`ifdef FPDIV_ROUND_EN
  localparam int unsigned ITERS = 26;
`else
  localparam int unsigned ITERS = 25;
`endif
  localparam int unsigned QW = ITERS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXP,
    S_ITER,
    S_NORM,
    S_DONE
  } state_t;

  state_t            state;
  logic [5:0]        step;
  logic              sign;
  logic [7:0]        ea;
  logic [7:0]        eb;
  logic [22:0]       ma;
  logic [22:0]       mb;
  logic signed [9:0] e;
  logic [24:0]       r;
  logic [24:0]       d;
  logic [QW-1:0]     q;

  logic              r_ge;
  logic [24:0]       r_sub;
  logic [22:0]       mant;
  logic signed [9:0] ex;
  logic [31:0]       norm_result;
`ifdef FPDIV_ROUND_EN
  logic              guard;
  logic              sticky;
  logic [23:0]       mant_inc;
`endif

  // One restoring step: trial subtraction of the divisor from the partial remainder.
  always_comb begin
    r_ge  = (r >= d);
    r_sub = r - d;
  end

  // Normalise the quotient, optionally round, then apply final exponent range checks.
  always_comb begin
    mant = '0;
    ex   = e;
    if (q[QW-1]) begin
      mant = q[QW-2 -: 23];
    end else begin
      mant = q[QW-3 -: 23];
      ex   = e - 10'sd1;
    end
`ifdef FPDIV_ROUND_EN
    guard    = q[QW-1] ? q[1] : q[0];
    sticky   = (q[QW-1] & q[0]) | (r != '0);
    mant_inc = {1'b0, mant} + 24'd1;
    if (guard & (sticky | mant[0])) begin
      // Carry out of the 23-bit mantissa renormalises to 1.0 x 2^(ex+1).
      if (mant_inc[23]) begin
        mant = '0;
        ex   = ex + 10'sd1;
      end else begin
        mant = mant_inc[22:0];
      end
    end
`endif
    if (ex <= 10'sd0) begin
      norm_result = {sign, 31'b0};
    end else if (ex >= 10'sd255) begin
      norm_result = {sign, 8'hFF, 23'b0};
    end else begin
      norm_result = {sign, ex[7:0], mant};
    end
  end

  // Control FSM and datapath registers; step counts edges since reset and holds in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      step   <= '0;
      sign   <= 1'b0;
      ea     <= '0;
      eb     <= '0;
      ma     <= '0;
      mb     <= '0;
      e      <= '0;
      r      <= '0;
      d      <= '0;
      q      <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          step <= step + 6'd1;
          sign <= dataa[31] ^ datab[31];
          ea   <= dataa[30:23];
          eb   <= datab[30:23];
          ma   <= dataa[22:0];
          mb   <= datab[22:0];
          if (dataa[30:23] == 8'd0) begin
            result <= {dataa[31] ^ datab[31], 31'b0};
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (datab[30:23] == 8'd0) begin
            result <= {dataa[31] ^ datab[31], 8'hFF, 23'b0};
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            state <= S_EXP;
          end
        end
        S_EXP: begin
          step  <= step + 6'd1;
          e     <= $signed({2'b00, ea} - {2'b00, eb} + 10'(EXP_BIAS));
          r     <= {2'b01, ma};
          d     <= {2'b01, mb};
          q     <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          step <= step + 6'd1;
          q    <= {q[QW-2:0], r_ge};
          r    <= r_ge ? {r_sub[23:0], 1'b0} : {r[23:0], 1'b0};
          if (step == 6'(ITERS + 1)) begin
            state <= S_NORM;
          end
        end
        S_NORM: begin
          step   <= step + 6'd1;
          result <= norm_result;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
